mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory stage directly downstream of the execute stage.
- Consumes the execute stage's ALU result, rs2 data, control word, rd and passthrough fields.
- Performs data-memory loads and stores through a request/response handshake and stalls the pipeline while an access is outstanding.
- Drives the registered MEM/WB boundary, including load data already aligned and extended for writeback.

Parameters:
- width, 32, datapath and address width. Only 32 is supported.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- MEM_valid_i  in  1  the incoming execute-stage bundle is a real instruction, not a bubble.
- MEM_alu_out_i  in  32  ALU result; the effective address for loads and stores.
- MEM_rs2_out_i  in  32  store data.
- MEM_ctrl_word_i  in  rv32i_control_word  uses fields mem_read, mem_write, funct3.
- MEM_rd_i  in  5  destination register.
- MEM_pc_out_i, MEM_pc_plus4_i, MEM_u_imm_i  in  32 each  passthrough to writeback.
- MEM_br_en_i  in  1  passthrough to writeback.
- MEM_stall_o  out  1  freezes the upstream pipeline registers.
- data_mem_read, data_mem_write  out  1 each  memory request strobes.
- data_mem_address  out  32  word-aligned address ({addr[31:2],2'b00}).
- data_mem_mbe  out  4  byte enables.
- data_mem_wdata  out  32  lane-shifted store data.
- data_mem_rdata  in  32  read data.
- data_mem_resp  in  1  access complete.
- WB_valid_o  out  1  registered output.
- WB_alu_out_o, WB_load_data_o, WB_pc_out_o, WB_pc_plus4_o, WB_u_imm_o  out  32 each  registered.
- WB_ctrl_word_o  out  rv32i_control_word  registered.
- WB_rd_o  out  5  registered.
- WB_br_en_o  out  1  registered.

Behaviour:
- memop = MEM_valid_i & (mem_read | mem_write). mem_read and mem_write are never both set.
- FSM states: IDLE, BUSY. Reset state is IDLE.
- IDLE, memop=1:
  - Latch address, mbe, wdata, funct3, the read/write kind, and the full input bundle into request registers.
  - Next state is BUSY.
  - MEM_stall_o=1 in this cycle.
- IDLE, memop=0:
  - Stay in IDLE; MEM_stall_o=0.
  - At the clock edge, load the WB_* registers from the inputs with WB_valid_o=MEM_valid_i and WB_load_data_o=0.
- BUSY:
  - data_mem_read / data_mem_write are driven from the latched kind.
  - address, mbe and wdata come from the request registers and stay stable until resp.
  - MEM_stall_o = ~data_mem_resp.
- BUSY with resp=1:
  - Load the WB_* registers from the latched bundle, with WB_load_data_o = extended load data (0 for stores) and WB_valid_o=1.
  - Next state is IDLE. Strobes drop at that edge.
- Bubbles: on every edge where MEM_stall_o=1, WB_valid_o<=0 and the other WB_* registers hold.
- Memory latency ≥1 cycle after request. Total occupancy per memory op is 1 + N cycles, where N is the number of BUSY cycles until resp.
- Strobes are never asserted in IDLE. Combinational same-cycle response is not required.
- Byte enables and store data, with a = addr[1:0]:
  - funct3 000 (SB): mbe = 4'b0001<<a; wdata = rs2<<(8*a).
  - funct3 001 (SH): mbe = 4'b0011<<{a[1],0}; wdata = rs2<<(16*a[1]).
  - funct3 010 (SW): mbe = 4'b1111; wdata = rs2.
  - Loads: mbe = 4'b1111.
- Load extraction from the rdata word, using the latched a:
  - LB sign-extends byte[a]; LBU zero-extends byte[a].
  - LH sign-extends half[a[1]]; LHU zero-extends half[a[1]].
  - LW passes the word through.
  - Undefined funct3 returns 0.
- Reset: asserting rst at any time, including mid-access, immediately forces:
  - state=IDLE;
  - strobes=0, MEM_stall_o=0;
  - all WB_* outputs = 0, including WB_ctrl_word_o and WB_valid_o.
  - An abandoned in-flight access is not retried; the memory side must tolerate it.
- A data_mem_resp that arrives in IDLE is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: in IDLE, when memop=1 and the access is misaligned (LH/LHU/SH with a[0]=1, or LW/SW with a≠0):
  - No request is issued and the FSM stays in IDLE; MEM_stall_o=0.
  - The WB registers load with WB_valid_o=1 and extra output WB_misaligned_o=1.
  - For misaligned loads, ctrl_word.load_regfile is forced to 0 in WB_ctrl_word_o.
  - WB_misaligned_o resets to 0 and is 0 for all other instructions.
- Not defined: the port WB_misaligned_o is absent. The low address bits are ignored beyond the lane rules above, and the access proceeds normally.

Test Plan:
- ALU op (add, no mem), valid=1, alu_out=0x1234 -> next edge WB_valid_o=1, WB_alu_out_o=0x1234, no strobes, stall=0.
- LB at 0x1003, rdata=0x80FF_0000 returned after 3 BUSY cycles -> address 0x1000, mbe=1111, stall held 4 cycles, WB_load_data_o=0xFFFF_FF80, bubbles (WB_valid_o=0) during the stall.
- SH at 0x2002, rs2=0x0000_ABCD, resp after 1 cycle -> mbe=1100, wdata=0xABCD_0000, write strobe for exactly 1 cycle, WB_load_data_o=0.
- LHU at 0x3002 with rdata=0xBEEF_1234 -> 0x0000_BEEF. LW at 0x3000 -> 0xBEEF_1234.
- rst asserted in BUSY during a load -> strobes and stall drop without waiting for a clock edge, WB_valid_o=0. A later resp pulse is ignored.
- With MEM_MISALIGN_TRAP_EN: LW at 0x4001 -> no strobes, stall=0, next edge WB_misaligned_o=1, load_regfile=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: data-memory stage with a request/response handshake and registered MEM/WB boundary.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses are not issued and are flagged on WB_misaligned_o.
`timescale 1ns/1ps
package rv32i_types;
    typedef struct packed {
        logic       load_regfile;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] funct3;
        logic [3:0] alu_op;
    } rv32i_control_word;
endpackage

module mem_stage
    import rv32i_types::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_valid_i,
    input  logic [WIDTH-1:0]  MEM_alu_out_i,
    input  logic [WIDTH-1:0]  MEM_rs2_out_i,
    input  rv32i_control_word MEM_ctrl_word_i,
    input  logic [4:0]        MEM_rd_i,
    input  logic [WIDTH-1:0]  MEM_pc_out_i,
    input  logic [WIDTH-1:0]  MEM_pc_plus4_i,
    input  logic [WIDTH-1:0]  MEM_u_imm_i,
    input  logic              MEM_br_en_i,
    output logic              MEM_stall_o,
    output logic              data_mem_read,
    output logic              data_mem_write,
    output logic [WIDTH-1:0]  data_mem_address,
    output logic [3:0]        data_mem_mbe,
    output logic [WIDTH-1:0]  data_mem_wdata,
    input  logic [WIDTH-1:0]  data_mem_rdata,
    input  logic              data_mem_resp,
    output logic              WB_valid_o,
    output logic [WIDTH-1:0]  WB_alu_out_o,
    output logic [WIDTH-1:0]  WB_load_data_o,
    output logic [WIDTH-1:0]  WB_pc_out_o,
    output logic [WIDTH-1:0]  WB_pc_plus4_o,
    output logic [WIDTH-1:0]  WB_u_imm_o,
    output rv32i_control_word WB_ctrl_word_o,
    output logic [4:0]        WB_rd_o,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic              WB_misaligned_o,
`endif
    output logic              WB_br_en_o
);
    typedef enum logic {IDLE, BUSY} state_e;
    typedef struct packed {
        logic [WIDTH-1:0]  alu;
        logic [WIDTH-1:0]  pc;
        logic [WIDTH-1:0]  pc4;
        logic [WIDTH-1:0]  uimm;
        rv32i_control_word ctrl;
        logic [4:0]        rd;
        logic              br;
    } bundle_t;

    state_e           state_q, state_d;
    bundle_t          in_b, req_q, req_d, wb_q, wb_d;
    logic [3:0]       mbe_q, mbe_d;
    logic [WIDTH-1:0] wdata_q, wdata_d, wb_ld_q, wb_ld_d, ld;
    logic             wb_valid_q, wb_valid_d, mis_q, mis_d;
    logic             busy, memop, misal, go;
    logic [1:0]       a;
    logic [2:0]       f3, rf3;
    logic [7:0]       rbyte;
    logic [15:0]      rhalf;

    always_comb begin
        in_b = '{alu: MEM_alu_out_i, pc: MEM_pc_out_i, pc4: MEM_pc_plus4_i, uimm: MEM_u_imm_i,
                 ctrl: MEM_ctrl_word_i, rd: MEM_rd_i, br: MEM_br_en_i};
        a = MEM_alu_out_i[1:0];
        f3 = MEM_ctrl_word_i.funct3;
        busy = state_q == BUSY;
        memop = MEM_valid_i & (MEM_ctrl_word_i.mem_read | MEM_ctrl_word_i.mem_write);
`ifdef MEM_MISALIGN_TRAP_EN
        misal = memop & (((f3[1:0] == 2'b01) & a[0]) | ((f3[1:0] == 2'b10) & (a != 2'b00)));
`else
        misal = 1'b0;
`endif
        go = memop & ~misal;
        MEM_stall_o = ~rst & (busy ? ~data_mem_resp : go);
        state_d = busy ? (data_mem_resp ? IDLE : BUSY) : (go ? BUSY : IDLE);
        mbe_d = (MEM_ctrl_word_i.mem_write & (f3 == 3'b000)) ? 4'b0001 << a :
                (MEM_ctrl_word_i.mem_write & (f3 == 3'b001)) ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
        wdata_d = (MEM_ctrl_word_i.mem_write & (f3 == 3'b000)) ? MEM_rs2_out_i << {a, 3'b000} :
                  (MEM_ctrl_word_i.mem_write & (f3 == 3'b001)) ? MEM_rs2_out_i << {a[1], 4'b0000} : MEM_rs2_out_i;
        req_d = (~busy & go) ? in_b : req_q;
        // Load lanes are selected with the address captured at request time.
        rf3 = req_q.ctrl.funct3;
        rbyte = 8'(data_mem_rdata >> {req_q.alu[1:0], 3'b000});
        rhalf = req_q.alu[1] ? data_mem_rdata[31:16] : data_mem_rdata[15:0];
        ld = ~req_q.ctrl.mem_read ? '0 :
             (rf3 == 3'b000) ? {{24{rbyte[7]}}, rbyte} :
             (rf3 == 3'b100) ? {24'b0, rbyte} :
             (rf3 == 3'b001) ? {{16{rhalf[15]}}, rhalf} :
             (rf3 == 3'b101) ? {16'b0, rhalf} :
             (rf3 == 3'b010) ? data_mem_rdata : '0;
        wb_d = wb_q;
        wb_ld_d = wb_ld_q;
        wb_valid_d = 1'b0;
        mis_d = 1'b0;
        if (busy & data_mem_resp) begin
            wb_d = req_q;
            wb_ld_d = ld;
            wb_valid_d = 1'b1;
        end else if (~busy & ~go) begin
            wb_d = in_b;
            wb_ld_d = '0;
            wb_valid_d = MEM_valid_i;
            mis_d = misal;
            if (misal & MEM_ctrl_word_i.mem_read) wb_d.ctrl.load_regfile = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q <= '0;
            mbe_q <= '0;
            wdata_q <= '0;
            wb_q <= '0;
            wb_ld_q <= '0;
            wb_valid_q <= 1'b0;
            mis_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q <= req_d;
            mbe_q <= (~busy & go) ? mbe_d : mbe_q;
            wdata_q <= (~busy & go) ? wdata_d : wdata_q;
            wb_q <= wb_d;
            wb_ld_q <= wb_ld_d;
            wb_valid_q <= wb_valid_d;
            mis_q <= mis_d;
        end
    end

    assign data_mem_read = busy & req_q.ctrl.mem_read;
    assign data_mem_write = busy & req_q.ctrl.mem_write;
    assign data_mem_address = {req_q.alu[WIDTH-1:2], 2'b00};
    assign data_mem_mbe = mbe_q;
    assign data_mem_wdata = wdata_q;
    assign WB_valid_o = wb_valid_q;
    assign WB_alu_out_o = wb_q.alu;
    assign WB_load_data_o = wb_ld_q;
    assign WB_pc_out_o = wb_q.pc;
    assign WB_pc_plus4_o = wb_q.pc4;
    assign WB_u_imm_o = wb_q.uimm;
    assign WB_ctrl_word_o = wb_q.ctrl;
    assign WB_rd_o = wb_q.rd;
    assign WB_br_en_o = wb_q.br;
`ifdef MEM_MISALIGN_TRAP_EN
    assign WB_misaligned_o = mis_q;
`else
    logic unused_mis;
    assign unused_mis = mis_q;
`endif
endmodule
